// File: rtl/ofifo_pkg.sv
// Shared width helpers and column slicing for the output FIFO.
package ofifo_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width: indexes 0..depth-1, wraps naturally for power-of-2 depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Low bit of column slice `col` in a packed COL*BW bus.
  function automatic int unsigned col_lo(input int unsigned col, input int unsigned bw);
    return col * bw;
  endfunction

endpackage

// File: rtl/ofifo_col_buf.sv
// One column of the output FIFO: circular buffer with occupancy count.
module ofifo_col_buf
  import ofifo_pkg::*;
#(
  parameter int unsigned BW    = 16,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned CNT_W = cnt_w(DEPTH),
  localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr,
  input  logic             pop,
  input  logic [BW-1:0]    in,
  output logic [BW-1:0]    out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [BW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop, do_wr;

  // A pop in the same cycle frees the slot, so a full column may still accept.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_wr    = wr && ((count_q != DEPTH_C) || do_pop);
    wr_ptr_d = do_wr  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_pop) count_d = count_q + CNT_W'(1);
    else if (!do_wr && do_pop) count_d = count_q - CNT_W'(1);
  end

  // Pointer and count state; flush behaves like reset on these.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since counts gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr && reset_n && !flush) mem[wr_ptr_q] <= in;
  end

  assign out   = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/ofifo_param.sv
// Column-aligned output FIFO: independent column writes, atomic row pops.
module ofifo_param
  import ofifo_pkg::*;
#(
  parameter int unsigned COL      = 8,
  parameter int unsigned BW       = 16,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AFULL_TH = 56,
  localparam int unsigned CNT_W   = cnt_w(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COL*BW-1:0]  in,
  input  logic [COL-1:0]     wr,
  input  logic               rd,
  input  logic               flush,
  input  logic [COL-1:0]     col_en,
  output logic [COL*BW-1:0]  out,
  output logic               o_out_valid,
  output logic               o_valid,
  output logic               o_ready,
  output logic               o_full,
  output logic               o_afull,
  output logic [CNT_W-1:0]   o_rows,
  output logic               o_overflow
);

  logic [CNT_W-1:0]  cnt [COL];
  logic [COL-1:0]    col_full, col_empty, col_pop;
  logic [COL*BW-1:0] head, out_d, out_q;
  logic              pop_fire, drop_any;
  logic              out_valid_q, overflow_q;

  assign pop_fire = rd && o_valid && !flush;

  for (genvar i = 0; i < COL; i++) begin : g_col
    assign col_pop[i] = pop_fire && col_en[i] && !col_empty[i];

    ofifo_col_buf #(.BW(BW), .DEPTH(DEPTH)) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .wr      (wr[i]),
      .pop     (col_pop[i]),
      .in      (in[col_lo(i, BW) +: BW]),
      .out     (head[col_lo(i, BW) +: BW]),
      .count   (cnt[i]),
      .full    (col_full[i]),
      .empty   (col_empty[i])
    );

    assign out_d[col_lo(i, BW) +: BW] = col_en[i] ? head[col_lo(i, BW) +: BW] : '0;
  end

  // A write is dropped only when its column is full and not popping this cycle.
  assign drop_any = |(wr & col_full & ~col_pop);

  // Flags from counts over enabled columns; none enabled yields zero rows.
  always_comb begin
    logic [CNT_W-1:0] rows_min;
    logic             any_en;
    rows_min = CNT_W'(DEPTH);
    any_en   = 1'b0;
    o_full   = 1'b0;
    o_afull  = 1'b0;
    for (int unsigned i = 0; i < COL; i++) begin
      if (col_en[i]) begin
        any_en = 1'b1;
        if (cnt[i] < rows_min) rows_min = cnt[i];
        if (col_full[i]) o_full = 1'b1;
        if (cnt[i] >= CNT_W'(AFULL_TH)) o_afull = 1'b1;
      end
    end
    o_rows  = any_en ? rows_min : '0;
    o_valid = (o_rows != '0);
    o_ready = !o_full;
  end

  // Output row register, out-valid strobe and sticky overflow; flush keeps out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= pop_fire;
      if (pop_fire) out_q <= out_d;
      if (drop_any) overflow_q <= 1'b1;
    end
  end

  assign out         = out_q;
  assign o_out_valid = out_valid_q;
  assign o_overflow  = overflow_q;

endmodule
